// File: rtl/fetch_pkg.sv
// Shared Fetch-stage definitions: state encoding, datapath width, PC defaults.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_mux.sv
// PC next-value select: sequential pc+PC_STEP or a redirect/pending target.
// Purely combinational, zero latency, no flow control.
module pc_next_mux
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_STEP = DEF_PC_STEP
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_tgt_pc,
  input  logic            i_sel,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_seq_pc;

  assign w_seq_pc  = i_pc + PC_STEP;
  assign o_next_pc = i_sel ? i_tgt_pc : w_seq_pc;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: issues imem req/ack reads into a one-entry slot (ack to if_valid = 1 cycle); stall holds the slot and
// blocks new launches, while an in-flight request always stays up until ack. FETCH_ALIGN_CHECK_EN adds misaligned-redirect HALT.
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            next_sel
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_out;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_instr;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_pc;

  logic            w_consume;
  logic            w_launch;
  logic            w_ack;
  logic            w_active;
  logic            w_redir;
  logic            w_misal;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_tgt_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pc_load;
  logic            w_slot_load;
  logic            w_flush;
  logic            w_pend_set;
  logic            w_pend_clr;

  assign w_consume  = r_if_valid & ~stall;
  assign w_launch   = (r_state == ST_REQ) & (~r_if_valid | ~stall);
  // r_out keeps an un-acked request (and its address) up regardless of stall
  assign imem_req   = r_out | w_launch;
  assign imem_addr  = r_pc;
  assign w_ack      = imem_req & imem_ack;
  assign w_active   = (r_state == ST_REQ) | (r_state == ST_DRAIN);
  assign w_redir_pc = redirect_pc & ~32'h3;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misal = redirect_valid & w_active & (redirect_pc[1:0] != 2'b00);
`else
  assign w_misal = 1'b0;
`endif

  assign w_redir  = redirect_valid & w_active & ~w_misal;
  // A redirect arriving alongside the draining ack is newer than pend_pc
  assign w_tgt_pc = (r_pend_valid && !w_redir) ? r_pend_pc : w_redir_pc;

  pc_next_mux #(
    .PC_STEP (PC_STEP)
  ) u_pc_next_mux (
    .i_pc      (r_pc),
    .i_tgt_pc  (w_tgt_pc),
    .i_sel     (next_sel),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    next_sel    = 1'b0;
    w_pc_load   = 1'b0;
    w_slot_load = 1'b0;
    w_flush     = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_misal) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_HALT;
        end else if (w_redir) begin
          w_flush = 1'b1;
          if (!imem_req || w_ack) begin
            next_sel  = 1'b1;
            w_pc_load = 1'b1;
          end else begin
            w_pend_set  = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end else if (w_ack) begin
          w_slot_load = 1'b1;
          w_pc_load   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_misal) begin
          w_flush     = 1'b1;
          w_pend_clr  = 1'b1;
          w_state_nxt = ST_HALT;
        end else begin
          w_flush = w_redir;
          if (w_ack) begin
            next_sel    = 1'b1;
            w_pc_load   = 1'b1;
            w_pend_clr  = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_pend_set = w_redir;
          end
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_HALT: w_flush = 1'b1;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_out        <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      if (w_pc_load) r_pc <= w_next_pc;
      r_out <= imem_req & ~imem_ack;
      if (w_flush) begin
        r_if_valid <= 1'b0;
      end else if (w_slot_load) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_instr <= imem_rdata;
      end else if (w_consume) begin
        r_if_valid <= 1'b0;
      end
      if (w_pend_clr) begin
        r_pend_valid <= 1'b0;
      end else if (w_pend_set) begin
        r_pend_valid <= 1'b1;
        r_pend_pc    <= w_redir_pc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst)          r_misalign <= 1'b0;
    else if (w_misal) r_misalign <= 1'b1;
  end

  assign fetch_misalign = r_misalign;
`endif

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: inputs change 1ns after posedge, outputs sampled 1ns later.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        next_sel;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory returns a word tagged with the low address bits so slot contents are traceable
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .next_sel       (next_sel)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b1;
    next_cyc();
    next_cyc();
    #1;
    check_eq("rst_req",    {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid",  {31'b0, if_valid}, 32'd0);
    check_eq("rst_if_pc",  if_pc,             32'd0);
    check_eq("rst_instr",  if_instr,          32'd0);
    check_eq("rst_sel",    {31'b0, next_sel}, 32'd0);
    check_eq("rst_addr",   imem_addr,         32'h3000);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_misal",  {31'b0, fetch_misalign}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check_eq("idle_req",   {31'b0, imem_req}, 32'd0);

    // Sequential fetch with ack tied high
    next_cyc(); #1;
    check_eq("seq0_req",   {31'b0, imem_req}, 32'd1);
    check_eq("seq0_addr",  imem_addr,         32'h3000);
    check_eq("seq0_valid", {31'b0, if_valid}, 32'd0);
    check_eq("seq0_sel",   {31'b0, next_sel}, 32'd0);
    next_cyc(); #1;
    check_eq("seq1_addr",  imem_addr,         32'h3004);
    check_eq("seq1_if_pc", if_pc,             32'h3000);
    check_eq("seq1_instr", if_instr,          32'hC0DE3000);
    check_eq("seq1_sel",   {31'b0, next_sel}, 32'd0);
    next_cyc();
    check_eq("seq2_addr",  imem_addr,         32'h3008);
    check_eq("seq2_if_pc", if_pc,             32'h3004);

    // Stall with full slot: slot held, no launch
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) next_cyc();
      #1;
      check_eq("stall_req",   {31'b0, imem_req}, 32'd0);
      check_eq("stall_valid", {31'b0, if_valid}, 32'd1);
      check_eq("stall_if_pc", if_pc,             32'h3004);
      check_eq("stall_instr", if_instr,          32'hC0DE3004);
    end
    next_cyc();
    stall = 1'b0; imem_ack = 1'b0;
    #1;
    check_eq("unstall_req",  {31'b0, imem_req}, 32'd1);
    check_eq("unstall_addr", imem_addr,         32'h3008);

    // Slow ack with a redirect in the 2nd waiting cycle
    next_cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    #1;
    check_eq("w2_addr",  imem_addr,         32'h3008);
    check_eq("w2_sel",   {31'b0, next_sel}, 32'd0);
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("w3_req",   {31'b0, imem_req}, 32'd1);
    check_eq("w3_addr",  imem_addr,         32'h3008);
    check_eq("w3_valid", {31'b0, if_valid}, 32'd0);
    next_cyc();
    imem_ack = 1'b1;
    #1;
    check_eq("drain_ack_sel",  {31'b0, next_sel}, 32'd1);
    check_eq("drain_ack_addr", imem_addr,         32'h3008);
    next_cyc(); #1;
    check_eq("redir_addr",  imem_addr,         32'h4000);
    check_eq("redir_valid", {31'b0, if_valid}, 32'd0);
    check_eq("redir_sel",   {31'b0, next_sel}, 32'd0);

    // Redirect coincident with an ack: slot not loaded
    next_cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    #1;
    check_eq("k_if_pc", if_pc,             32'h4000);
    check_eq("k_instr", if_instr,          32'hC0DE4000);
    check_eq("k_addr",  imem_addr,         32'h4004);
    check_eq("k_sel",   {31'b0, next_sel}, 32'd1);
    next_cyc();
    check_eq("l_valid", {31'b0, if_valid}, 32'd0);
    check_eq("l_addr",  imem_addr,         32'h5000);

    // Two redirects during one drain: the latest wins
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h6000;
    #1;
    check_eq("l_sel",   {31'b0, next_sel}, 32'd0);
    next_cyc();
    redirect_pc = 32'h7000;
    #1;
    check_eq("m_addr",  imem_addr,         32'h5000);
    check_eq("m_sel",   {31'b0, next_sel}, 32'd0);
    next_cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    #1;
    check_eq("n_sel",   {31'b0, next_sel}, 32'd1);
    next_cyc();
    check_eq("o_addr",  imem_addr,         32'h7000);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h4002;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("mis_sel", {31'b0, next_sel}, 32'd0);
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("mis_flag",  {31'b0, fetch_misalign}, 32'd1);
    check_eq("mis_req",   {31'b0, imem_req},       32'd0);
    check_eq("mis_valid", {31'b0, if_valid},       32'd0);
    next_cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h8000;
    #1;
    check_eq("halt_sel",  {31'b0, next_sel},       32'd0);
    check_eq("halt_req",  {31'b0, imem_req},       32'd0);
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("halt_flag", {31'b0, fetch_misalign}, 32'd1);
    check_eq("halt_req2", {31'b0, imem_req},       32'd0);
`else
    check_eq("mis_sel", {31'b0, next_sel}, 32'd1);
    next_cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("mis_addr",  imem_addr,         32'h4000);
    check_eq("mis_req",   {31'b0, imem_req}, 32'd1);
    check_eq("mis_valid", {31'b0, if_valid}, 32'd0);
`endif

    // Reset mid-stream
    rst = 1'b1;
    next_cyc(); #1;
    check_eq("rst2_req",   {31'b0, imem_req}, 32'd0);
    check_eq("rst2_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst2_addr",  imem_addr,         32'h3000);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst2_misal", {31'b0, fetch_misalign}, 32'd0);
`endif
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
